// File: rtl/sort4_sequencer.sv
// Four-element sorter: one compare-exchange per cycle over w0..w3 using a single 4-bit comparator.
// Optional macro SORT4_EARLY_EXIT_EN ends the sort after any pass that made no swap.

module magnitude_comparator (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       agtb
);
    assign agtb = (a > b);
endmodule

module sort4_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    output logic       busy,
    output logic       done,
    output logic [3:0] s0,
    output logic [3:0] s1,
    output logic [3:0] s2,
    output logic [3:0] s3
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [3:0] w_q [4];
    logic [3:0] w_d [4];
    logic [3:0] s_q [4];
    logic [3:0] s_d [4];

    logic [1:0] idx_lo, idx_hi;
    logic [3:0] cmp_a, cmp_b;
    logic       agtb;
    logic       swap;
    logic       last_step;

    // Pair position for each step: (0,1) (1,2) (2,3) (0,1) (1,2) (0,1)
    always_comb begin
        idx_lo = 2'd0;
        case (step_q)
            3'd1:    idx_lo = 2'd1;
            3'd2:    idx_lo = 2'd2;
            3'd4:    idx_lo = 2'd1;
            default: idx_lo = 2'd0;
        endcase
    end

    assign idx_hi = idx_lo + 2'd1;
    assign cmp_a  = w_q[idx_lo];
    assign cmp_b  = w_q[idx_hi];

    magnitude_comparator u_cmp (
        .a    (cmp_a),
        .b    (cmp_b),
        .agtb (agtb)
    );

    assign swap = (state_q == CMP) && agtb;

`ifdef SORT4_EARLY_EXIT_EN
    logic flag_q, flag_d;
    logic pass_end;

    assign pass_end  = (step_q == 3'd2) || (step_q == 3'd4) || (step_q == 3'd5);
    assign last_step = (step_q == 3'd5) || (pass_end && !(flag_q || swap));

    always_comb begin
        flag_d = flag_q;
        if (state_q == IDLE && start) begin
            flag_d = 1'b0;
        end else if (state_q == CMP) begin
            flag_d = pass_end ? 1'b0 : (flag_q | swap);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) flag_q <= 1'b0;
        else     flag_q <= flag_d;
    end
`else
    assign last_step = (step_q == 3'd5);
`endif

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        w_d     = w_q;
        s_d     = s_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    w_d[0]  = d0;
                    w_d[1]  = d1;
                    w_d[2]  = d2;
                    w_d[3]  = d3;
                    step_d  = 3'd0;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (swap) begin
                    w_d[idx_lo] = w_q[idx_hi];
                    w_d[idx_hi] = w_q[idx_lo];
                end
                // Results are captured post-exchange so the final step is included.
                if (last_step) begin
                    s_d     = w_d;
                    state_d = DONE;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= 3'd0;
            for (int k = 0; k < 4; k++) begin
                w_q[k] <= 4'd0;
                s_q[k] <= 4'd0;
            end
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            w_q     <= w_d;
            s_q     <= s_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign s0   = s_q[0];
    assign s1   = s_q[1];
    assign s2   = s_q[2];
    assign s3   = s_q[3];

endmodule

// File: tb/tb_sort4_sequencer.sv
// Scoreboard bench for sort4_sequencer: stimulus pushes expected result and done cycle,
// a monitor pops on every done pulse and compares.

module tb_sort4_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic       busy, done;
    logic [3:0] s0, s1, s2, s3;

    typedef struct {
        logic [15:0] res;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

`ifdef SORT4_EARLY_EXIT_EN
    localparam int SORTED_LAT = 4;
`else
    localparam int SORTED_LAT = 7;
`endif

    sort4_sequencer dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .busy  (busy),
        .done  (done),
        .s0    (s0),
        .s1    (s1),
        .s2    (s2),
        .s3    (s3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issues one start; returns the cycle count of the accepting edge.
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [3:0] d, output int acc);
        @(negedge clk);
        d0 = a; d1 = b; d2 = c; d3 = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] res, input int done_cyc);
        exp_t e;
        e.res = res;
        e.cyc = done_cyc;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || sb.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            tests++;
            fails++;
            $display("[TB] FAIL wait_idle: timeout busy=%0b pending=%0d", busy, sb.size());
        end
    endtask

    initial begin
        int acc;
        int nbusy;
        exp_t e;

        fork
            forever begin
                @(negedge clk);
                if (!rst && done) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                    end else begin
                        e = sb.pop_front();
                        check("result", {s0, s1, s2, s3}, e.res);
                        check("done_cycle", cyc, e.cyc);
                    end
                end
            end
        join_none

        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_s", {s0, s1, s2, s3}, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reverse order, with busy duration
        issue(4'h9, 4'h7, 4'h3, 4'h1, acc);
        push_exp(16'h1379, acc + 6);
        nbusy = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) nbusy++;
        end
        check("busy_cycles", nbusy, 7);
        wait_idle();

        // Duplicates and extremes
        issue(4'hF, 4'h0, 4'hF, 4'h0, acc);
        push_exp(16'h00FF, acc + 6);
        wait_idle();

        // Already sorted
        issue(4'h2, 4'h4, 4'h6, 4'h8, acc);
        push_exp(16'h2468, acc + SORTED_LAT - 1);
        wait_idle();

        // All equal: never swapped, so it also qualifies for early exit
        issue(4'h3, 4'h3, 4'h3, 4'h3, acc);
        push_exp(16'h3333, acc + SORTED_LAT - 1);
        wait_idle();

        // Reset during step3 aborts without a done pulse
        issue(4'h5, 4'h1, 4'h4, 4'h2, acc);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_s", {s0, s1, s2, s3}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        issue(4'h5, 4'h1, 4'h4, 4'h2, acc);
        push_exp(16'h1245, acc + 6);
        wait_idle();

        // start during CMP is ignored; outputs hold the previous result meanwhile
        issue(4'h6, 4'h2, 4'h9, 4'h0, acc);
        push_exp(16'h0269, acc + 6);
        @(negedge clk);
        d0 = 4'h1; d1 = 4'h1; d2 = 4'h1; d3 = 4'h1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hold_s_mid", {s0, s1, s2, s3}, 16'h1245);
        @(negedge clk);
        check("hold_s_late", {s0, s1, s2, s3}, 16'h1245);
        wait_idle();

        // start held high: two back-to-back sorts, one IDLE cycle apart
        @(negedge clk);
        d0 = 4'h3; d1 = 4'h0; d2 = 4'h2; d3 = 4'h1;
        start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        d0 = 4'h8; d1 = 4'h8; d2 = 4'h1; d3 = 4'h1;
        push_exp(16'h0123, acc + 6);
        push_exp(16'h1188, acc + 14);
        repeat (9) @(negedge clk);
        start = 1'b0;
        wait_idle();

        repeat (12) @(negedge clk);
        check("final_idle", {busy, done}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sort4_sequencer.md
SORT4_SEQUENCER -- requirements
Module: sort4_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising-edge; rst  in  1  asynchronous, active-high reset.
REQ-002 SHALL have ports: start  in  1  request to sort; d0,d1,d2,d3  in  4 each  unsigned operands, sampled only when start is accepted.
REQ-003 SHALL have ports: busy  out  1  sort in progress; done  out  1  one-cycle completion pulse; s0,s1,s2,s3  out  4 each  sorted result, s0 smallest.
REQ-004 SHALL perform every magnitude decision with exactly one instance of the team's 4-bit magnitude_comparator, using only its agtb output; no other magnitude compare logic.

Function
REQ-005 SHALL implement FSM states IDLE, CMP, DONE; reset state IDLE.
REQ-006 IDLE: start=1 at a rising edge SHALL load d0..d3 into working regs w0..w3, clear step counter to 0, and enter CMP.
REQ-007 start SHALL be ignored in CMP and DONE; there is no queuing of requests.
REQ-008 CMP SHALL execute one compare-exchange per cycle in fixed order: step0 (w0,w1), step1 (w1,w2), step2 (w2,w3), step3 (w0,w1), step4 (w1,w2), step5 (w0,w1).
REQ-009 Each step SHALL drive the comparator with a=w[i], b=w[i+1] and swap the pair at the clock edge iff agtb=1; equal values are not swapped.
REQ-010 Step counter SHALL be 3 bits, increment once per CMP cycle, and never exceed 5; after step5, next state SHALL be DONE.
REQ-011 On the CMP->DONE edge, s0..s3 SHALL be loaded from the final w0..w3; s0..s3 SHALL otherwise hold their values, including through the next sort, until the next DONE.
REQ-012 done SHALL be 1 only in DONE, for exactly one cycle; DONE SHALL always return to IDLE.
REQ-013 busy SHALL be 1 in CMP and DONE and 0 in IDLE.
REQ-014 Latency without the REQ-019 macro SHALL be fixed: start accepted at edge N, done high in the cycle after edge N+6.
REQ-015 start held high continuously SHALL cause back-to-back sorts with one IDLE cycle between done and the next acceptance.

Reset
REQ-016 rst=1 SHALL asynchronously force: state IDLE, step 0, w0..w3=0, s0..s3=0, busy=0, done=0.
REQ-017 rst asserted mid-sort SHALL abort the sort with no done pulse; the first start after rst release SHALL be handled normally.

Configuration
REQ-018 Macro SORT4_EARLY_EXIT_EN SHALL select early termination.
REQ-019 Early termination with SORT4_EARLY_EXIT_EN defined: passes are steps0-2, steps3-4, and step5; a per-pass swap flag SHALL clear at pass start; a pass ending with flag=0 SHALL go directly to DONE, skipping the remaining steps. Fully sorted input therefore gives done in the cycle after edge N+3.
REQ-020 Without SORT4_EARLY_EXIT_EN, the swap flag logic SHALL be absent and latency SHALL always follow REQ-014; sorted results SHALL be identical in both builds.

Verification
REQ-021 Reverse order, d0..d3=9,7,3,1, start pulsed -> done 7 cycles after acceptance; s0..s3=1,3,7,9; busy high for 7 cycles.
REQ-022 Duplicates and extremes, d0..d3=F,0,F,0 -> s0..s3=0,0,F,F; no swap occurs on equal pairs.
REQ-023 Already sorted 2,4,6,8 -> s=2,4,6,8; done after 7 cycles without the macro, 4 cycles with SORT4_EARLY_EXIT_EN.
REQ-024 rst pulsed during step3 of a 5,1,4,2 sort -> no done; busy=0 and s0..s3=0 immediately; a following start with 5,1,4,2 gives 1,2,4,5.
REQ-025 start pulsed again during CMP with new d values -> ignored; result matches the first operands; s0..s3 remain stable until the next done.
REQ-026 start held high across two sorts, 3,0,2,1 then 8,8,1,1 -> two done pulses separated by one IDLE cycle; results 0,1,2,3 and 1,1,8,8.
